// File: rtl/multi_channel_timer.sv
// N_CH independent down-counting timers (one-shot or periodic) with start/stop/pause,
// registered expiry pulse, sticky expiry flag and a combinational count readback mux.

module mct_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] delay,
  input  logic             clear_expired,
  output logic             tick,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] count
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, dly_q, dly_d;
  logic             per_q, per_d, tick_q, tick_d, exp_q, exp_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      per_q   <= 1'b0;
      tick_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      per_q   <= per_d;
      tick_q  <= tick_d;
      exp_q   <= exp_d;
    end
  end

  // stop > start > pause > count; a restart in RUN swallows an expiry due this cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    per_d   = per_q;
    tick_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d = RUN;
      cnt_d   = delay;
      dly_d   = delay;
      per_d   = periodic;
    end else if (state_q == RUN && !pause) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        tick_d = 1'b1;
        if (per_q) cnt_d = dly_q;
        else       state_d = IDLE;
      end
    end
    exp_d = tick_d | (exp_q & ~clear_expired);
  end

  always_comb begin
    tick    = tick_q;
    expired = exp_q;
    busy    = (state_q == RUN);
    count   = cnt_q;
  end
endmodule

module multi_channel_timer #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         stop,
  input  logic [N_CH-1:0]         pause,
  input  logic [N_CH-1:0]         periodic,
  input  logic [N_CH*WIDTH-1:0]   delay,
  input  logic [N_CH-1:0]         clear_expired,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         expired,
  output logic [N_CH-1:0]         busy,
  output logic                    any_expired,
  output logic [WIDTH-1:0]        rd_count
);
  logic [N_CH-1:0][WIDTH-1:0] cnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mct_channel #(.WIDTH(WIDTH)) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start[g]),
      .stop         (stop[g]),
      .pause        (pause[g]),
      .periodic     (periodic[g]),
      .delay        (delay[g*WIDTH +: WIDTH]),
      .clear_expired(clear_expired[g]),
      .tick         (tick[g]),
      .expired      (expired[g]),
      .busy         (busy[g]),
      .count        (cnt[g])
    );
  end

  assign any_expired = |expired;

  // selects that match no channel fall through to zero
  always_comb begin
    rd_count = '0;
    for (int i = 0; i < N_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_count = cnt[i];
  end
endmodule

// File: tb/tb_multi_channel_timer.sv
// Randomised + directed bench for multi_channel_timer: a cycles-to-expiry reference
// model feeds a scoreboard queue that an independent monitor drains every clock.

module tb_multi_channel_timer;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int SW = 3;   // wide enough to address non-existent channels

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   start, stop, pause, periodic, clear_expired;
  logic [N*W-1:0] delay;
  logic [SW-1:0]  rd_sel;
  logic [N-1:0]   tick, expired, busy;
  logic           any_expired;
  logic [W-1:0]   rd_count;

  multi_channel_timer #(.N_CH(N), .WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .delay(delay), .clear_expired(clear_expired), .rd_sel(rd_sel),
    .tick(tick), .expired(expired), .busy(busy), .any_expired(any_expired),
    .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] tick, expd, busy;
    logic         any;
    logic [W-1:0] rd;
  } exp_t;
  exp_t sbq[$];

  int n_chk = 0, n_fail = 0;
  int unsigned edge_n = 0, s_k = 0;
  int unsigned last_tick[N];

  // model: cycles remaining until the expiry edge (count + 1) while running
  bit m_run[N], m_per[N], m_exp[N];
  int m_left[N], m_dly[N];

  // stimulus staging
  logic           s_rn = 1'b0;
  logic [N-1:0]   s_start = '0, s_stop = '0, s_pause = '0, s_per = '0, s_clr = '0;
  logic [N*W-1:0] s_delay = '0;
  logic [SW-1:0]  s_sel = '0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, req, edge_n);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_per[i] = 0; m_exp[i] = 0; m_left[i] = 0; m_dly[i] = 0;
    end
  endfunction

  task automatic step();
    exp_t e;
    @(negedge clk);
    reset_n = s_rn; start = s_start; stop = s_stop; pause = s_pause;
    periodic = s_per; delay = s_delay; clear_expired = s_clr; rd_sel = s_sel;
    s_k = edge_n + 1;
    e.tick = '0;
    if (!s_rn) model_reset();
    else begin
      for (int i = 0; i < N; i++) begin
        if (s_stop[i]) begin
          m_run[i] = 0; m_left[i] = 0;
        end else if (s_start[i]) begin
          m_run[i] = 1; m_dly[i] = int'(s_delay[i*W +: W]); m_per[i] = s_per[i];
          m_left[i] = m_dly[i] + 1;
        end else if (m_run[i] && !s_pause[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            e.tick[i] = 1'b1;
            if (m_per[i]) m_left[i] = m_dly[i] + 1;
            else          m_run[i] = 0;
          end
        end
        m_exp[i] = e.tick[i] | (m_exp[i] & ~s_clr[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      e.expd[i] = m_exp[i];
      e.busy[i] = m_run[i];
    end
    e.any = |e.expd;
    e.rd  = (int'(s_sel) < N && m_run[int'(s_sel)]) ? W'(m_left[int'(s_sel)] - 1) : '0;
    sbq.push_back(e);
    s_start = '0; s_stop = '0; s_clr = '0;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(int ch, int d, bit per);
    s_delay[ch*W +: W] = W'(d);
    s_per[ch] = per;
    s_start[ch] = 1'b1;
  endtask

  // monitor: every edge, compare whatever expectation the driver queued for it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      edge_n++;
      for (int i = 0; i < N; i++) if (tick[i] === 1'b1) last_tick[i] = edge_n;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("tick",        64'(tick),        64'(e.tick));
        chk("expired",     64'(expired),     64'(e.expd));
        chk("busy",        64'(busy),        64'(e.busy));
        chk("any_expired", 64'(any_expired), 64'(e.any));
        chk("rd_count",    64'(rd_count),    64'(e.rd));
      end
    end
  end

  initial begin
    int unsigned k;
    for (int i = 0; i < N; i++) last_tick[i] = 0;
    model_reset();
    start = '0; stop = '0; pause = '0; periodic = '0; delay = '0;
    clear_expired = '0; rd_sel = '0;
    steps(3);
    s_rn = 1'b1;

    // one-shot ch0 D=3
    arm(0, 3, 0); step(); k = s_k;
    steps(7);
    chk("oneshot_latency", 64'(last_tick[0] - k), 64'd4);
    s_clr[0] = 1'b1; steps(2);

    // periodic ch1 D=2, stop at the edge its 4th tick would fire
    s_sel = 3'd1;
    arm(1, 2, 1); step(); k = s_k;
    steps(11);
    s_stop[1] = 1'b1; step();
    steps(6);
    chk("periodic_last_tick", 64'(last_tick[1] - k), 64'd9);

    // pause ch2 D=5 for 4 cycles mid-count
    s_sel = 3'd2;
    arm(2, 5, 0); step(); k = s_k;
    steps(2);
    s_pause[2] = 1'b1; steps(4);
    s_pause[2] = 1'b0; steps(8);
    chk("pause_latency", 64'(last_tick[2] - k), 64'd10);

    // restart ch3 exactly when its count hits zero, then stop+start together
    s_sel = 3'd3;
    arm(3, 2, 0); step();
    steps(2);
    arm(3, 4, 0); step(); k = s_k;
    steps(8);
    chk("restart_latency", 64'(last_tick[3] - k), 64'd5);
    arm(3, 7, 1); s_stop[3] = 1'b1; step();
    steps(2);

    // tick and clear in the same cycle on ch0
    s_sel = 3'd0;
    arm(0, 1, 0); step();
    step();
    s_clr[0] = 1'b1; step();
    steps(2);

    // D=0 gives tick one edge after start
    arm(0, 0, 0); step(); k = s_k;
    steps(3);
    chk("d0_latency", 64'(last_tick[0] - k), 64'd1);

    // delay/periodic changes mid-run are ignored
    s_sel = 3'd1;
    arm(1, 3, 1); step();
    steps(2);
    s_delay[1*W +: W] = W'(9); s_per[1] = 1'b0;
    steps(10);
    s_stop[1] = 1'b1; step();

    // out-of-range selects
    for (int v = 4; v < 8; v++) begin
      s_sel = SW'(v); arm(2, 6, 0); step();
    end
    s_stop[2] = 1'b1; step();

    // full-range delay on ch0
    s_sel = 3'd0;
    arm(0, 65535, 0); step(); k = s_k;
    for (int i = 0; i < 65540; i++) begin
      if (i % 4096 == 0) s_sel = SW'($urandom_range(0, 7));
      step();
    end
    chk("dmax_latency", 64'(last_tick[0] - k), 64'd65536);

    // async reset with all channels running, then no ticks until restarted
    for (int i = 0; i < N; i++) arm(i, 5 + 3 * i, i[0]);
    s_sel = 3'd2;
    step();
    steps(3);
    @(posedge clk); #3;
    reset_n = 1'b0; s_rn = 1'b0; model_reset();
    #1;
    chk("rst_busy",     64'(busy),        64'd0);
    chk("rst_tick",     64'(tick),        64'd0);
    chk("rst_expired",  64'(expired),     64'd0);
    chk("rst_any",      64'(any_expired), 64'd0);
    chk("rst_rd_count", 64'(rd_count),    64'd0);
    steps(2);
    s_rn = 1'b1;
    steps(30);

    // randomised traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        s_start[i] = ($urandom_range(0, 15) == 0);
        s_stop[i]  = ($urandom_range(0, 39) == 0);
        s_clr[i]   = ($urandom_range(0, 7) == 0);
        s_per[i]   = $urandom_range(0, 1);
        if ($urandom_range(0, 9) == 0) s_pause[i] = ~s_pause[i];
        s_delay[i*W +: W] = W'($urandom_range(0, 10));
      end
      s_sel = SW'($urandom_range(0, 7));
      step();
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
